transmit_comm: RTL and testbench

//  Parallel-to-serial UART-style transmitter; the stage feeding the serial line into the receive stage.

---
 rtl/comm_pkg.sv | 24 ++
 rtl/transmit_comm_bit_timer.sv | 31 +++
 rtl/transmit_comm.sv | 148 ++++++++++++++
 tb/tb_transmit_comm.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared serial-link definitions: FSM state encoding, line levels and default
// framing constants used by both the transmit and receive stages.
package comm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

   localparam int unsigned DEF_OVERSAMPLE = 16;
   localparam int unsigned DEF_DATA_BITS  = 8;

   // Width of a down-counter able to hold values 0..n-1, never narrower than 1.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/transmit_comm_bit_timer.sv
// bit_timer: free-running OVERSAMPLE sample counter with synchronous clear;
// bit_tick marks the last sample of each serial bit period.
module bit_timer
   import comm_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic bit_tick
);

   localparam int unsigned CW = idx_width(OVERSAMPLE);

   logic [CW-1:0] count_q;

   // OVERSAMPLE is a power of two, so the natural binary wrap gives the modulo.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count_q <= '0;
      else if (clear)
         count_q <= '0;
      else if (enable)
         count_q <= count_q + 1'b1;
   end

   assign bit_tick = enable && (count_q == CW'(OVERSAMPLE - 1));

endmodule

// File: rtl/transmit_comm.sv
// transmit_comm: parallel-to-serial UART-style transmitter, start bit, MSB-first
// data, optional even parity (define TX_PARITY_EN), STOP_BITS stop bits.
module transmit_comm
   import comm_pkg::*;
#(
   parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
   parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] parallel_in,
   input  logic                 load,
   output logic                 ready,
   output logic                 serial_out,
   output logic                 char_sent,
   output logic                 busy
);

   localparam int unsigned IW = idx_width((DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS);

   tx_state_t              state_q, state_d;
   logic [DATA_BITS-1:0]   shreg_q, shreg_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic                   serial_q, serial_d;
   logic                   char_sent_q, char_sent_d;
   logic                   accept;
   logic                   bit_tick;
`ifdef TX_PARITY_EN
   logic                   parity_q, parity_d;
`endif

   assign ready      = (state_q == ST_IDLE);
   assign busy       = ~ready;
   assign accept     = load && ready;
   assign serial_out = serial_q;
   assign char_sent  = char_sent_q;

   bit_timer #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_bit_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (accept),
      .enable   (busy),
      .bit_tick (bit_tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         shreg_q     <= '0;
         idx_q       <= '0;
         serial_q    <= IDLE_LEVEL;
         char_sent_q <= 1'b0;
`ifdef TX_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         idx_q       <= idx_d;
         serial_q    <= serial_d;
         char_sent_q <= char_sent_d;
`ifdef TX_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      idx_d       = idx_q;
      char_sent_d = 1'b0;
`ifdef TX_PARITY_EN
      parity_d    = parity_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_START;
               shreg_d = parallel_in;
               idx_d   = '0;
`ifdef TX_PARITY_EN
               parity_d = ^parallel_in;
`endif
            end
         end
         ST_START: begin
            if (bit_tick) begin
               state_d = ST_DATA;
               idx_d   = IW'(DATA_BITS - 1);
            end
         end
         ST_DATA: begin
            if (bit_tick) begin
               shreg_d = shreg_q << 1;
               if (idx_q == '0) begin
`ifdef TX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
                  idx_d   = IW'(STOP_BITS - 1);
`endif
               end else begin
                  idx_d = idx_q - 1'b1;
               end
            end
         end
`ifdef TX_PARITY_EN
         ST_PARITY: begin
            if (bit_tick) begin
               state_d = ST_STOP;
               idx_d   = IW'(STOP_BITS - 1);
            end
         end
`endif
         ST_STOP: begin
            if (bit_tick) begin
               if (idx_q == '0) begin
                  state_d     = ST_IDLE;
                  char_sent_d = 1'b1;
               end else begin
                  idx_d = idx_q - 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Line level is decoded from the next state so the register changes on the
   // same edge as the FSM, giving a glitch-free output aligned to state.
   always_comb begin
      serial_d = IDLE_LEVEL;
      case (state_d)
         ST_START:  serial_d = START_LEVEL;
         ST_DATA:   serial_d = shreg_d[DATA_BITS-1];
`ifdef TX_PARITY_EN
         ST_PARITY: serial_d = parity_d;
`endif
         default:   serial_d = IDLE_LEVEL;
      endcase
   end

endmodule

// File: tb/tb_transmit_comm.sv
// Directed self-checking bench for transmit_comm; frame layout follows
// TX_PARITY_EN when defined.
module tb_transmit_comm;

   localparam int OS = 16;
`ifdef TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] parallel_in;
   logic       load;
   logic       ready;
   logic       serial_out;
   logic       char_sent;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;

   transmit_comm #(
      .DATA_BITS  (8),
      .OVERSAMPLE (OS),
      .STOP_BITS  (1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .parallel_in (parallel_in),
      .load        (load),
      .ready       (ready),
      .serial_out  (serial_out),
      .char_sent   (char_sent),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic frame_bit(input logic [7:0] d, input int b);
      if (b == 0)
         return 1'b0;
      else if (b <= 8)
         return d[8-b];
`ifdef TX_PARITY_EN
      else if (b == 9)
         return ^d;
`endif
      else
         return 1'b1;
   endfunction

   // Waits (bounded) for ready, then holds load across one edge; returns #1 after
   // the accepting edge.
   task automatic accept(input logic [7:0] d, input string name);
      int n = 0;
      parallel_in = d;
      load = 1'b1;
      while (!ready && n < 1000) begin
         tick();
         n++;
      end
      check({name, "_ready"}, ready, 1'b1);
      tick();
      load = 1'b0;
      parallel_in = ~d;
   endtask

   // Entered #1 after the accepting edge; leaves #1 after the edge ending the frame.
   task automatic check_frame(input logic [7:0] d, input int inj, input string name);
      logic exp_bit, mid, stable;
      int   early_cs = 0;
      int   ready_hi = 0;
      for (int b = 0; b < FRAME_BITS; b++) begin
         exp_bit = frame_bit(d, b);
         stable  = 1'b1;
         mid     = 1'bx;
         for (int k = 0; k < OS; k++) begin
            if (k == OS / 2) mid = serial_out;
            if (serial_out !== exp_bit) stable = 1'b0;
            if (char_sent) early_cs++;
            if (ready) ready_hi++;
            if (b * OS + k == inj) begin
               load = 1'b1;
               parallel_in = 8'h55;
            end else if (b * OS + k == inj + 1) begin
               load = 1'b0;
            end
            tick();
         end
         check($sformatf("%s_bit%0d", name, b), {stable, mid}, {1'b1, exp_bit});
      end
      check({name, "_no_early_cs"}, early_cs, 0);
      check({name, "_busy_frame"}, ready_hi, 0);
      check({name, "_char_sent"}, char_sent, 1'b1);
      check({name, "_ready_end"}, ready, 1'b1);
   endtask

   initial begin
      int bad;
      reset = 1'b1;
      load = 1'b0;
      parallel_in = 8'h00;
      tick();
      tick();
      check("rst_serial", serial_out, 1'b1);
      check("rst_ready", ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_char_sent", char_sent, 1'b0);
      reset = 1'b0;

      // 1: idle line
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         if (serial_out !== 1'b1 || ready !== 1'b1 || char_sent !== 1'b0) bad++;
         tick();
      end
      check("idle_100", bad, 0);

      // 2: single frame A5
      accept(8'hA5, "a5");
      check("a5_busy", busy, 1'b1);
      check_frame(8'hA5, -1, "a5");
      tick();
      check("a5_cs_pulse", char_sent, 1'b0);

      // 3: back-to-back 3C then FF, load issued in the char_sent cycle
      accept(8'h3C, "3c");
      check_frame(8'h3C, -1, "3c");
      parallel_in = 8'hFF;
      load = 1'b1;
      tick();
      load = 1'b0;
      parallel_in = 8'h00;
      check("b2b_start", serial_out, 1'b0);
      check_frame(8'hFF, -1, "ff");
      tick();

      // 4: load while busy is ignored
      accept(8'h00, "z");
      check_frame(8'h00, 40, "z");
      tick();

      // 5: async reset mid-data
      accept(8'h0F, "r");
      for (int i = 0; i < 70; i++) tick();
      check("r_pre_line", serial_out, 1'b0);
      reset = 1'b1;
      #1;
      check("r_line_high", serial_out, 1'b1);
      check("r_ready", ready, 1'b1);
      check("r_cs", char_sent, 1'b0);
      tick();
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         if (char_sent !== 1'b0 || serial_out !== 1'b1) bad++;
         tick();
      end
      check("r_quiet", bad, 0);
      accept(8'h81, "x81");
      check_frame(8'h81, -1, "x81");
      tick();

`ifdef TX_PARITY_EN
      // 6: parity frame
      accept(8'h07, "p07");
      check_frame(8'h07, -1, "p07");
      tick();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
